// File: rtl/dual_spi_rx.sv
// Dual-line SPI receiver: synchronises the host's ss/sclk/dibit lines into clk,
// assembles bytes from four dibits MSB first, and queues them with a first-of-frame tag.
module dual_spi_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       io_ss,
  input  logic       io_sclk,
  input  logic [1:0] io_qd_read,
  output logic [7:0] out_data,
  output logic       out_first,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_end,
  output logic       overrun,
  input  logic       clear_overrun,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] ss_pipe, sclk_pipe;
  logic [1:0]             qd_pipe [SYNC_STAGES];
  logic                   ss_s, sclk_s, sclk_prev, sclk_rise;
  logic [1:0]             qd_s;

  state_t     state_q, state_d;
  logic [5:0] shift;
  logic [1:0] cnt;
  logic       first_pending;
  logic       shift_en, byte_done, frame_end_d;
  logic [7:0] wr_byte;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          push, pop, drop, full, bypass;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_pipe   <= '1;
      sclk_pipe <= '0;
      sclk_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) qd_pipe[i] <= 2'b00;
    end else begin
      ss_pipe    <= {ss_pipe[SYNC_STAGES-2:0], io_ss};
      sclk_pipe  <= {sclk_pipe[SYNC_STAGES-2:0], io_sclk};
      sclk_prev  <= sclk_s;
      qd_pipe[0] <= io_qd_read;
      for (int i = 1; i < SYNC_STAGES; i++) qd_pipe[i] <= qd_pipe[i-1];
    end
  end

  assign ss_s      = ss_pipe[SYNC_STAGES-1];
  assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
  assign qd_s      = qd_pipe[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign wr_byte   = {shift, qd_s};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // A byte finishing on the same cycle ss is seen high is still pushed; byte_done
  // does not depend on the exit condition.
  always_comb begin
    state_d     = state_q;
    shift_en    = 1'b0;
    byte_done   = 1'b0;
    frame_end_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ss_s) state_d = ACTIVE;
      end
      ACTIVE: begin
        shift_en  = sclk_rise;
        byte_done = sclk_rise && (cnt == 2'd3);
        if (ss_s) begin
          state_d     = IDLE;
          frame_end_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == ACTIVE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift         <= '0;
      cnt           <= '0;
      first_pending <= 1'b0;
      frame_end     <= 1'b0;
    end else begin
      frame_end <= frame_end_d;
      if (state_q == IDLE && state_d == ACTIVE) begin
        cnt           <= '0;
        first_pending <= 1'b1;
      end else if (state_q == ACTIVE) begin
        if (shift_en) begin
          shift <= {shift[3:0], qd_s};
          cnt   <= cnt + 2'd1;
        end
        if (byte_done) first_pending <= 1'b0;
        if (ss_s) begin
          shift <= '0;
          cnt   <= '0;
        end
      end
    end
  end

  // Output handshake: a byte leaves the FIFO on a rising clk edge where out_valid
  // and out_ready are both high; out_valid stays high until that pop empties the FIFO.
  assign pop    = out_valid & out_ready;
  assign full   = (count == CW'(FIFO_DEPTH));
  assign push   = byte_done & (~full | pop);
  assign drop   = byte_done & full & ~pop;
  assign bypass = push & (pop ? (count == CW'(1)) : (count == '0));

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
    rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {first_pending, wr_byte};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_first <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      // A byte landing in an otherwise empty FIFO is forwarded straight to the head.
      if (bypass)                  {out_first, out_data} <= {first_pending, wr_byte};
      else if (count_nxt != '0)    {out_first, out_data} <= mem[rd_ptr_nxt];
      if (drop)               overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
    end
  end

endmodule
